// File: rtl/cgra_ctrl_pkg.sv
// Shared types and default sizing for the CGRA fabric controllers.
package cgra_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ctrl_state_e;

    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_PIPE_DEPTH = 5;
    localparam int unsigned DEF_CLR_CYCLES = 1;

endpackage

// File: rtl/ctrl_down_counter.sv
// Loadable down-counter with enable; stops at zero and flags it.
module ctrl_down_counter #(
    parameter int unsigned W = 16
) (
    input  logic         CLK,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/kernel_loop_ctrl.sv
// Loop sequencer for a mapped single-loop CGRA kernel: clear, issue, drain, capture.
// Optional stall-cycle performance counter enabled by KERNEL_LOOP_CTRL_PERF_EN.
module kernel_loop_ctrl
    import cgra_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int unsigned CLR_CYCLES = DEF_CLR_CYCLES
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] trip_count,
    input  logic             stall,
    input  logic             cmp_exit,
    input  logic [WIDTH-1:0] acc_in,
    output logic             kernel_en,
    output logic             kernel_rst,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] iter_count
`ifdef KERNEL_LOOP_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    ctrl_state_e      state;
    logic [CNT_W-1:0] tc;
    logic [CNT_W-1:0] iter_next;
    logic             accept;
    logic             issue;
    logic             last_issue;
    logic             clr_zero;
    logic             drain_zero;

    assign accept     = (state == IDLE) && start;
    assign issue      = (state == RUN) && !stall;
    assign iter_next  = iter_count + CNT_W'(1);
    assign last_issue = issue && ((iter_next == tc) || cmp_exit);

    assign kernel_en  = ((state == RUN) || (state == DRAIN)) && !stall;
    assign kernel_rst = (state == CLEAR);

    // Both counters are preloaded with length-1 on accept; the phase ends on the cycle they read zero.
    ctrl_down_counter #(.W(CNT_W)) u_clr_cnt (
        .CLK      (CLK),
        .resetn   (resetn),
        .load     (accept),
        .load_val (CNT_W'(CLR_CYCLES - 1)),
        .en       (state == CLEAR),
        .zero     (clr_zero)
    );

    ctrl_down_counter #(.W(CNT_W)) u_drain_cnt (
        .CLK      (CLK),
        .resetn   (resetn),
        .load     (accept),
        .load_val (CNT_W'(PIPE_DEPTH - 1)),
        .en       ((state == DRAIN) && !stall),
        .zero     (drain_zero)
    );

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            tc         <= '0;
            iter_count <= '0;
            result     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tc         <= trip_count;
                        iter_count <= '0;
                        busy       <= 1'b1;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_zero) begin
                        state <= (tc == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        iter_count <= iter_next;
                    end
                    if (last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!stall && drain_zero) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // A zero-trip run never enables the fabric, so its accumulator is not meaningful.
                    result <= (tc == '0) ? '0 : acc_in;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef KERNEL_LOOP_CTRL_PERF_EN
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if (((state == RUN) || (state == DRAIN)) && stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_kernel_loop_ctrl.sv
// Scoreboard bench for kernel_loop_ctrl with a behavioural fabric and loop model.
module tb_kernel_loop_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int PD    = 5;
    localparam int CLR   = 1;

    logic             CLK = 1'b0;
    logic             resetn;
    logic             start;
    logic [CNT_W-1:0] trip_count;
    logic             stall;
    logic             cmp_exit;
    logic [WIDTH-1:0] acc_in;
    logic             kernel_en;
    logic             kernel_rst;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] iter_count;
`ifdef KERNEL_LOOP_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    kernel_loop_ctrl #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .PIPE_DEPTH (PD),
        .CLR_CYCLES (CLR)
    ) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .start      (start),
        .trip_count (trip_count),
        .stall      (stall),
        .cmp_exit   (cmp_exit),
        .acc_in     (acc_in),
        .kernel_en  (kernel_en),
        .kernel_rst (kernel_rst),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .iter_count (iter_count)
`ifdef KERNEL_LOOP_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int unsigned      due;
        logic [CNT_W-1:0] n;
        logic [WIDTH-1:0] sum;
        int               pulses;
        int               stalls;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    bit          stall_seq [256];
    bit          cmp_seq   [256];
    logic [15:0] vals      [256];

    logic [WIDTH-1:0] last_sum;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Loop semantics over the post-CLEAR cycle sequence: issues, drain length, stalled cycles.
    function automatic void walk(input int tc, output int n, output int len, output int st);
        int drained;
        bit draining;
        drained  = 0;
        draining = 1'b0;
        n = 0; len = 0; st = 0;
        if (tc == 0) return;
        for (int k = 0; k < 256; k++) begin
            if (stall_seq[k]) begin
                st++;
            end else if (!draining) begin
                n++;
                if (n == tc || cmp_seq[k]) draining = 1'b1;
            end else begin
                drained++;
                if (drained == PD) begin
                    len = k + 1;
                    return;
                end
            end
        end
        len = 256;
    endfunction

    // Fabric stand-in: a PD-deep product pipeline feeding an accumulator, advanced by kernel_en.
    logic [WIDTH-1:0] pipe [PD];
    int fab_k;
    always @(negedge CLK) begin
        if (!resetn || kernel_rst) begin
            acc_in = '0;
            fab_k  = 0;
            for (int i = 0; i < PD; i++) pipe[i] = '0;
        end else if (kernel_en) begin
            acc_in = acc_in + pipe[PD-1];
            for (int i = PD - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = (fab_k < 256) ? WIDTH'(vals[fab_k]) : '0;
            fab_k++;
        end
    end

    int   mon_pulses;
    int   mon_rst;
    bit   prev_done;
    exp_t e;
    always @(negedge CLK) begin
        if (!resetn) begin
            mon_pulses = 0;
            mon_rst    = 0;
            prev_done  = 1'b0;
        end else begin
            if (kernel_rst) begin
                mon_pulses = 0;
                mon_rst++;
            end
            if (kernel_en) mon_pulses++;
            if (prev_done) check("done_width", done, 0);
            prev_done = done;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc, e.due);
                    check("iter_count", iter_count, e.n);
                    check("result", result, e.sum);
                    check("en_pulses", mon_pulses, e.pulses);
                    check("rst_cycles", mon_rst, CLR);
                    check("busy_at_done", busy, 0);
`ifdef KERNEL_LOOP_CTRL_PERF_EN
                    check("stall_cycles", stall_cycles, e.stalls);
`endif
                end
                mon_rst = 0;
            end else if (sb.size() != 0 && cyc > sb[0].due + 4) begin
                check("done_timeout", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic clear_seq();
        for (int k = 0; k < 256; k++) begin
            stall_seq[k] = 1'b0;
            cmp_seq[k]   = 1'b0;
            vals[k]      = 16'($urandom);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_kernel_en"}, kernel_en, 0);
        check({tag, "_kernel_rst"}, kernel_rst, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_iter_count"}, iter_count, 0);
    endtask

    task automatic run(input int tc, input int abort_at, input bit poke_start);
        int n, len, st;
        logic [WIDTH-1:0] sum;
        exp_t x;
        check("result_hold", result, last_sum);
        walk(tc, n, len, st);
        sum = '0;
        for (int i = 0; i < n; i++) sum = sum + WIDTH'(vals[i]);
        x.due    = cyc + 2 + CLR + len;
        x.n      = CNT_W'(n);
        x.sum    = sum;
        x.pulses = (tc == 0) ? 0 : n + PD;
        x.stalls = st;
        start      = 1'b1;
        trip_count = CNT_W'(tc);
        if (abort_at < 0) sb.push_back(x);
        @(posedge CLK); #1;
        start      = 1'b0;
        trip_count = CNT_W'($urandom);
        repeat (CLR) begin
            stall    = 1'($urandom);
            cmp_exit = 1'($urandom);
            @(posedge CLK); #1;
        end
        for (int k = 0; k < len; k++) begin
            stall    = stall_seq[k];
            cmp_exit = cmp_seq[k];
            if (k == abort_at) begin
                resetn = 1'b0;
                #1;
                check_zero_outputs("abort");
                sb.delete();
                stall    = 1'b0;
                cmp_exit = 1'b0;
                @(posedge CLK); #3;
                resetn = 1'b1;
                @(posedge CLK); #1;
                last_sum = '0;
                return;
            end
            start = poke_start && (k == len / 2);
            @(posedge CLK); #1;
            start = 1'b0;
        end
        start    = poke_start;
        stall    = 1'($urandom);
        cmp_exit = 1'($urandom);
        @(posedge CLK); #1;
        start    = 1'b0;
        stall    = 1'b0;
        cmp_exit = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        last_sum = sum;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        stall      = 1'b0;
        cmp_exit   = 1'b0;
        trip_count = '0;
        last_sum   = '0;
        clear_seq();
        repeat (3) @(posedge CLK);
        #1;
        check_zero_outputs("reset");
        resetn = 1'b1;
        @(posedge CLK); #1;

        clear_seq();
        run(20, -1, 1'b0);

        clear_seq();
        for (int k = 8; k <= 10; k++) stall_seq[k] = 1'b1;
        stall_seq[24] = 1'b1;
        stall_seq[25] = 1'b1;
        run(20, -1, 1'b0);

        clear_seq();
        cmp_seq[7] = 1'b1;
        run(20, -1, 1'b0);

        clear_seq();
        stall_seq[5] = 1'b1;
        cmp_seq[5]   = 1'b1;
        run(20, -1, 1'b0);

        clear_seq();
        run(0, -1, 1'b0);

        clear_seq();
        run(12, -1, 1'b1);
        clear_seq();
        run(7, -1, 1'b0);

        clear_seq();
        run(30, 10, 1'b0);
        clear_seq();
        run(4, -1, 1'b0);

        for (int r = 0; r < 25; r++) begin
            clear_seq();
            for (int k = 0; k < 128; k++) begin
                stall_seq[k] = ($urandom_range(0, 3) == 0);
                cmp_seq[k]   = ($urandom_range(0, 31) == 0);
            end
            run(int'($urandom_range(0, 40)), -1, 1'($urandom));
        end

        repeat (4) @(posedge CLK);
        #1;
        if (sb.size() != 0) check("pending_at_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
